axi4_lite_demux: RTL and testbench

//  Parametrised 1-to-NUM_SLAVES AXI4-Lite demux. Sits between one AXI4-Lite master and N AXI4-Lite slaves.

---
 rtl/axi4_lite_demux_if.sv | 71 +++++++
 rtl/axi4_lite_demux.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_axi4_lite_demux.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_demux_if.sv
// AXI4-Lite demux bus bundle: one upstream port (S_*) and N flattened
// downstream ports (M_*), lane i at [i*W +: W].
interface axi4_lite_demux_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int N  = 4
);
  localparam int SW = DW / 8;

  logic [AW-1:0]   S_AWADDR;
  logic            S_AWVALID;
  logic            S_AWREADY;
  logic [DW-1:0]   S_WDATA;
  logic [SW-1:0]   S_WSTRB;
  logic            S_WVALID;
  logic            S_WREADY;
  logic [1:0]      S_BRESP;
  logic            S_BVALID;
  logic            S_BREADY;
  logic [AW-1:0]   S_ARADDR;
  logic            S_ARVALID;
  logic            S_ARREADY;
  logic [DW-1:0]   S_RDATA;
  logic [1:0]      S_RRESP;
  logic            S_RVALID;
  logic            S_RREADY;

  logic [N*AW-1:0] M_AWADDR;
  logic [N-1:0]    M_AWVALID;
  logic [N-1:0]    M_AWREADY;
  logic [N*DW-1:0] M_WDATA;
  logic [N*SW-1:0] M_WSTRB;
  logic [N-1:0]    M_WVALID;
  logic [N-1:0]    M_WREADY;
  logic [N*2-1:0]  M_BRESP;
  logic [N-1:0]    M_BVALID;
  logic [N-1:0]    M_BREADY;
  logic [N*AW-1:0] M_ARADDR;
  logic [N-1:0]    M_ARVALID;
  logic [N-1:0]    M_ARREADY;
  logic [N*DW-1:0] M_RDATA;
  logic [N*2-1:0]  M_RRESP;
  logic [N-1:0]    M_RVALID;
  logic [N-1:0]    M_RREADY;

  modport slave (
    input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB,
    input  S_WVALID, S_BREADY, S_ARADDR, S_ARVALID,
    input  S_RREADY,
    output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    output M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB,
    output M_WVALID, M_BREADY, M_ARADDR, M_ARVALID,
    output M_RREADY,
    input  M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );

  modport master (
    output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB,
    output S_WVALID, S_BREADY, S_ARADDR, S_ARVALID,
    output S_RREADY,
    input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    input  M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB,
    input  M_WVALID, M_BREADY, M_ARADDR, M_ARVALID,
    input  M_RREADY,
    output M_AWREADY, M_WREADY, M_BRESP, M_BVALID,
    output M_ARREADY, M_RDATA, M_RRESP, M_RVALID
  );
endinterface

// File: rtl/axi4_lite_demux.sv
// 1-to-N AXI4-Lite demux, one outstanding access per path, DECERR on miss.
// Optional watchdog + sticky FAULT: define AXI4_LITE_DEMUX_TIMEOUT_EN.
module axi4_lite_demux #(
  parameter int              DATA_WIDTH     = 32,
  parameter int              ADDRESS        = 32,
  parameter int              NUM_SLAVES     = 4,
  parameter logic [ADDRESS-1:0] BASE_ADDR   = '0,
  parameter int              REGION_BITS    = 12,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic ACLK,
  input  logic ARESET,
  axi4_lite_demux_if.slave bus
`ifdef AXI4_LITE_DEMUX_TIMEOUT_EN
  ,
  output logic [NUM_SLAVES-1:0] FAULT
`endif
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_BACK} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_WAIT, R_BACK} r_state_t;

  function automatic logic hit_f(input logic [ADDRESS-1:0] a);
    logic [ADDRESS-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) &&
           ((off >> REGION_BITS) < ADDRESS'(NUM_SLAVES));
  endfunction

  function automatic logic [IW-1:0] idx_f(input logic [ADDRESS-1:0] a);
    logic [ADDRESS-1:0] off;
    off = (a - BASE_ADDR) >> REGION_BITS;
    return off[IW-1:0];
  endfunction

  function automatic logic [NUM_SLAVES-1:0] lane_f(input logic [IW-1:0] i);
    return NUM_SLAVES'(1) << i;
  endfunction

  w_state_t              w_st;
  r_state_t              r_st;
  logic                  w_to, r_to;
  logic [NUM_SLAVES-1:0] fault_q;

  logic                  aw_got, wd_got;
  logic [ADDRESS-1:0]    aw_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [SW-1:0]         ws_q;
  logic [IW-1:0]         w_idx;
  logic                  s_awready, s_wready, s_bvalid;
  logic [1:0]            s_bresp;
  logic [NUM_SLAVES-1:0] m_awvalid, m_wvalid, m_bready;

  logic [ADDRESS-1:0]    ar_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [IW-1:0]         r_idx;
  logic                  s_arready, s_rvalid;
  logic [1:0]            s_rresp;
  logic [NUM_SLAVES-1:0] m_arvalid, m_rready;

  logic                  aw_hs, wd_hs, aw_now, wd_now, ar_hs;
  logic [ADDRESS-1:0]    aw_cur;
  logic [IW-1:0]         aw_idx, ar_idx;
  logic                  aw_hit, ar_hit, aw_ok, wd_ok;

  assign aw_hs  = s_awready && bus.S_AWVALID;
  assign wd_hs  = s_wready && bus.S_WVALID;
  assign aw_now = aw_got || aw_hs;
  assign wd_now = wd_got || wd_hs;
  assign aw_cur = aw_got ? aw_q : bus.S_AWADDR;
  assign aw_hit = hit_f(aw_cur);
  assign aw_idx = idx_f(aw_cur);
  assign ar_hs  = s_arready && bus.S_ARVALID;
  assign ar_hit = hit_f(bus.S_ARADDR);
  assign ar_idx = idx_f(bus.S_ARADDR);
  assign aw_ok  = !m_awvalid[w_idx] || bus.M_AWREADY[w_idx];
  assign wd_ok  = !m_wvalid[w_idx] || bus.M_WREADY[w_idx];

  assign bus.S_AWREADY = s_awready;
  assign bus.S_WREADY  = s_wready;
  assign bus.S_BVALID  = s_bvalid;
  assign bus.S_BRESP   = s_bresp;
  assign bus.S_ARREADY = s_arready;
  assign bus.S_RVALID  = s_rvalid;
  assign bus.S_RRESP   = s_rresp;
  assign bus.S_RDATA   = rd_q;
  assign bus.M_AWADDR  = {NUM_SLAVES{aw_q}};
  assign bus.M_WDATA   = {NUM_SLAVES{wd_q}};
  assign bus.M_WSTRB   = {NUM_SLAVES{ws_q}};
  assign bus.M_ARADDR  = {NUM_SLAVES{ar_q}};
  assign bus.M_AWVALID = m_awvalid;
  assign bus.M_WVALID  = m_wvalid;
  assign bus.M_BREADY  = m_bready;
  assign bus.M_ARVALID = m_arvalid;
  assign bus.M_RREADY  = m_rready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_st      <= W_IDLE;
      aw_got    <= 1'b0;
      wd_got    <= 1'b0;
      aw_q      <= '0;
      wd_q      <= '0;
      ws_q      <= '0;
      w_idx     <= '0;
      s_awready <= 1'b0;
      s_wready  <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      m_awvalid <= '0;
      m_wvalid  <= '0;
      m_bready  <= '0;
    end else begin
      unique case (w_st)
        W_IDLE: begin
          if (aw_hs) begin
            aw_q   <= bus.S_AWADDR;
            aw_got <= 1'b1;
          end
          if (wd_hs) begin
            wd_q   <= bus.S_WDATA;
            ws_q   <= bus.S_WSTRB;
            wd_got <= 1'b1;
          end
          if (aw_now && wd_now) begin
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            aw_got    <= 1'b0;
            wd_got    <= 1'b0;
            w_idx     <= aw_idx;
            if (!aw_hit || fault_q[aw_idx]) begin
              s_bresp  <= aw_hit ? 2'b10 : 2'b11;
              s_bvalid <= 1'b1;
              w_st     <= W_BACK;
            end else begin
              m_awvalid <= lane_f(aw_idx);
              m_wvalid  <= lane_f(aw_idx);
              w_st      <= W_FWD;
            end
          end else begin
            s_awready <= !aw_now;
            s_wready  <= !wd_now;
          end
        end
        W_FWD: begin
          if (w_to) begin
            m_awvalid <= '0;
            m_wvalid  <= '0;
            s_bresp   <= 2'b10;
            s_bvalid  <= 1'b1;
            w_st      <= W_BACK;
          end else begin
            if (bus.M_AWREADY[w_idx]) m_awvalid <= '0;
            if (bus.M_WREADY[w_idx])  m_wvalid  <= '0;
            if (aw_ok && wd_ok) begin
              m_bready <= lane_f(w_idx);
              w_st     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (w_to) begin
            m_bready <= '0;
            s_bresp  <= 2'b10;
            s_bvalid <= 1'b1;
            w_st     <= W_BACK;
          end else if (bus.M_BVALID[w_idx]) begin
            m_bready <= '0;
            s_bresp  <= bus.M_BRESP[w_idx*2 +: 2];
            s_bvalid <= 1'b1;
            w_st     <= W_BACK;
          end
        end
        W_BACK: begin
          if (bus.S_BREADY) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_st      <= W_IDLE;
          end
        end
        default: w_st <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_st      <= R_IDLE;
      ar_q      <= '0;
      rd_q      <= '0;
      r_idx     <= '0;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rresp   <= 2'b00;
      m_arvalid <= '0;
      m_rready  <= '0;
    end else begin
      unique case (r_st)
        R_IDLE: begin
          if (ar_hs) begin
            ar_q      <= bus.S_ARADDR;
            r_idx     <= ar_idx;
            s_arready <= 1'b0;
            if (!ar_hit || fault_q[ar_idx]) begin
              rd_q     <= '0;
              s_rresp  <= ar_hit ? 2'b10 : 2'b11;
              s_rvalid <= 1'b1;
              r_st     <= R_BACK;
            end else begin
              m_arvalid <= lane_f(ar_idx);
              r_st      <= R_FWD;
            end
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_FWD: begin
          if (r_to) begin
            m_arvalid <= '0;
            rd_q      <= '0;
            s_rresp   <= 2'b10;
            s_rvalid  <= 1'b1;
            r_st      <= R_BACK;
          end else if (bus.M_ARREADY[r_idx]) begin
            m_arvalid <= '0;
            m_rready  <= lane_f(r_idx);
            r_st      <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_to) begin
            m_rready <= '0;
            rd_q     <= '0;
            s_rresp  <= 2'b10;
            s_rvalid <= 1'b1;
            r_st     <= R_BACK;
          end else if (bus.M_RVALID[r_idx]) begin
            m_rready <= '0;
            rd_q     <= bus.M_RDATA[r_idx*DATA_WIDTH +: DATA_WIDTH];
            s_rresp  <= bus.M_RRESP[r_idx*2 +: 2];
            s_rvalid <= 1'b1;
            r_st     <= R_BACK;
          end
        end
        R_BACK: begin
          if (bus.S_RREADY) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_st      <= R_IDLE;
          end
        end
        default: r_st <= R_IDLE;
      endcase
    end
  end

`ifdef AXI4_LITE_DEMUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] w_cnt, r_cnt;
  logic          w_act, r_act;

  assign w_act = (w_st == W_FWD) || (w_st == W_RESP);
  assign r_act = (r_st == R_FWD) || (r_st == R_WAIT);
  // fires on the TIMEOUT_CYCLES-th cycle spent waiting on the slave
  assign w_to  = w_act && (w_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign r_to  = r_act && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign FAULT = fault_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_cnt   <= '0;
      r_cnt   <= '0;
      fault_q <= '0;
    end else begin
      w_cnt <= (w_act && !w_to) ? w_cnt + 1'b1 : '0;
      r_cnt <= (r_act && !r_to) ? r_cnt + 1'b1 : '0;
      if (w_to) fault_q[w_idx] <= 1'b1;
      if (r_to) fault_q[r_idx] <= 1'b1;
    end
  end
`else
  assign w_to    = 1'b0;
  assign r_to    = 1'b0;
  assign fault_q = '0;
`endif
endmodule

// File: tb/tb_axi4_lite_demux.sv
// Randomised self-checking bench for axi4_lite_demux (N=4, 4 KiB windows
// from address 0); lane slaves are always-ready, zero-latency responders.
module tb_axi4_lite_demux;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi4_lite_demux_if #(.DW(32), .AW(32), .N(N)) bus ();

`ifdef AXI4_LITE_DEMUX_TIMEOUT_EN
  logic [N-1:0] fault;
`endif

  axi4_lite_demux #(
    .DATA_WIDTH(32), .ADDRESS(32), .NUM_SLAVES(N),
    .BASE_ADDR(32'h0), .REGION_BITS(12), .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK(clk),
    .ARESET(rst),
    .bus(bus.slave)
`ifdef AXI4_LITE_DEMUX_TIMEOUT_EN
    ,
    .FAULT(fault)
`endif
  );

  logic [N-1:0] aw_rdy, w_rdy, ar_rdy, bv_en, rv_en;
  logic [1:0]   bresp_l [N];
  logic [1:0]   rresp_l [N];
  logic [31:0]  rdata_l [N];

  assign bus.M_AWREADY = aw_rdy;
  assign bus.M_WREADY  = w_rdy;
  assign bus.M_ARREADY = ar_rdy;
  assign bus.M_BVALID  = bv_en;
  assign bus.M_RVALID  = rv_en;
  for (genvar i = 0; i < N; i++) begin : g_sl
    assign bus.M_BRESP[i*2 +: 2]  = bresp_l[i];
    assign bus.M_RRESP[i*2 +: 2]  = rresp_l[i];
    assign bus.M_RDATA[i*32 +: 32] = rdata_l[i];
  end

  // downstream observer: handshakes per lane and lane-crossing events
  int          aw_n [N];
  int          w_n  [N];
  int          ar_n [N];
  int          aw_tot = 0, w_tot = 0, ar_tot = 0, cross_n = 0;
  logic [31:0] aw_a [N];
  logic [31:0] ar_a [N];
  logic [31:0] w_d  [N];
  logic [3:0]  w_s  [N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.M_AWVALID[i] && aw_rdy[i]) begin
        aw_n[i]++; aw_tot++;
        aw_a[i] = bus.M_AWADDR[i*32 +: 32];
      end
      if (bus.M_WVALID[i] && w_rdy[i]) begin
        w_n[i]++; w_tot++;
        w_d[i] = bus.M_WDATA[i*32 +: 32];
        w_s[i] = bus.M_WSTRB[i*4 +: 4];
      end
      if (bus.M_ARVALID[i] && ar_rdy[i]) begin
        ar_n[i]++; ar_tot++;
        ar_a[i] = bus.M_ARADDR[i*32 +: 32];
      end
    end
    if ($countones(bus.M_AWVALID) > 1 || $countones(bus.M_WVALID) > 1 ||
        $countones(bus.M_ARVALID) > 1 || $countones(bus.M_BREADY) > 1 ||
        $countones(bus.M_RREADY) > 1)
      cross_n++;
  end

  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                          input int awd, wd,
                          output logic [1:0] resp, output int lat);
    bit ad = 0, wdn = 0;
    int c = 0;
    while (!(ad && wdn) && c < 200) begin
      @(negedge clk);
      bus.S_AWADDR  = a;
      bus.S_WDATA   = d;
      bus.S_WSTRB   = s;
      bus.S_AWVALID = !ad && c >= awd;
      bus.S_WVALID  = !wdn && c >= wd;
      if (bus.S_AWVALID && bus.S_AWREADY) ad = 1;
      if (bus.S_WVALID && bus.S_WREADY) wdn = 1;
      c++;
    end
    lat = 0;
    do begin
      @(negedge clk);
      bus.S_AWVALID = 1'b0;
      bus.S_WVALID  = 1'b0;
      bus.S_BREADY  = 1'b1;
      lat++;
    end while (!bus.S_BVALID && lat < 100);
    resp = bus.S_BRESP;
    @(negedge clk);
    bus.S_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input int rrd,
                         output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output bit stable);
    bit done = 0;
    int c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      bus.S_ARADDR  = a;
      bus.S_ARVALID = 1'b1;
      if (bus.S_ARREADY) done = 1;
      c++;
    end
    lat = 0;
    do begin
      @(negedge clk);
      bus.S_ARVALID = 1'b0;
      bus.S_RREADY  = 1'b0;
      lat++;
    end while (!bus.S_RVALID && lat < 100);
    data   = bus.S_RDATA;
    resp   = bus.S_RRESP;
    stable = 1;
    repeat (rrd) begin
      @(negedge clk);
      if (!bus.S_RVALID || bus.S_RDATA !== data || bus.S_RRESP !== resp)
        stable = 0;
    end
    bus.S_RREADY = 1'b1;
    @(negedge clk);
    bus.S_RREADY = 1'b0;
    if (bus.S_RVALID) stable = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_ARREADY,
         bus.S_RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_s_handshake: got %b want 00000",
               {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID,
                bus.S_ARREADY, bus.S_RVALID});
    end
    checks++;
    if (bus.S_BRESP !== 2'b00 || bus.S_RRESP !== 2'b00 ||
        bus.S_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_s_payload: bresp=%b rresp=%b rdata=%h want 0",
               bus.S_BRESP, bus.S_RRESP, bus.S_RDATA);
    end
    checks++;
    if ({bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY, bus.M_ARVALID,
         bus.M_RREADY} !== '0 || bus.M_AWADDR !== '0 ||
        bus.M_WDATA !== '0 || bus.M_WSTRB !== '0 || bus.M_ARADDR !== '0) begin
      errors++;
      $display("FAIL reset_m_side: valid/ready=%h addr=%h want all 0",
               {bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY,
                bus.M_ARVALID, bus.M_RREADY}, bus.M_AWADDR);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic [1:0] r;
    int lat, a0, t0, wt0;
    bresp_l[1] = 2'b00;
    a0 = aw_n[1]; t0 = aw_tot; wt0 = w_tot;
    do_write(32'h0000_1004, 32'hA5A5_0001, 4'hF, 0, 0, r, lat);
    repeat (2) @(negedge clk);
    checks++;
    if (r !== 2'b00 || lat != 3) begin
      errors++;
      $display("FAIL wr_basic_resp: resp=%b lat=%0d want resp=00 lat=3",
               r, lat);
    end
    checks++;
    if (aw_n[1] - a0 != 1 || aw_tot - t0 != 1 || w_tot - wt0 != 1 ||
        aw_a[1] !== 32'h0000_1004 || w_d[1] !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL wr_basic_fwd: lane1=%0d tot=%0d addr=%h data=%h want 1 1 00001004 a5a50001",
               aw_n[1] - a0, aw_tot - t0, aw_a[1], w_d[1]);
    end
  endtask

  task automatic test_write_order();
    logic [1:0] r;
    int lat, t0, wt0;
    int awd [2];
    int wdl [2];
    awd[0] = 0; wdl[0] = 5;
    awd[1] = 5; wdl[1] = 0;
    bresp_l[2] = 2'b10;
    for (int k = 0; k < 2; k++) begin
      t0 = aw_n[2]; wt0 = w_tot;
      do_write(32'h0000_2008 + k * 4, 32'h1234_0000 + k, 4'b0110,
               awd[k], wdl[k], r, lat);
      repeat (2) @(negedge clk);
      checks++;
      if (r !== 2'b10 || lat != 3) begin
        errors++;
        $display("FAIL wr_order%0d_resp: resp=%b lat=%0d want 10 3",
                 k, r, lat);
      end
      checks++;
      if (aw_n[2] - t0 != 1 || w_tot - wt0 != 1 || w_s[2] !== 4'b0110 ||
          w_d[2] !== 32'h1234_0000 + k) begin
        errors++;
        $display("FAIL wr_order%0d_fwd: aw=%0d w=%0d strb=%b data=%h",
                 k, aw_n[2] - t0, w_tot - wt0, w_s[2], w_d[2]);
      end
    end
  endtask

  task automatic test_read_miss();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, t0;
    bit st;
    t0 = ar_tot;
    do_read(32'h0000_5000, 0, d, r, lat, st);
    checks++;
    if (r !== 2'b11 || d !== 32'h0 || lat != 1 || ar_tot != t0) begin
      errors++;
      $display("FAIL rd_miss: resp=%b data=%h lat=%0d fwd=%0d want 11 0 1 0",
               r, d, lat, ar_tot - t0);
    end
  endtask

  task automatic test_read_stall();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, t0;
    bit st;
    rdata_l[2] = 32'hDEAD_BEEF;
    rresp_l[2] = 2'b00;
    t0 = ar_n[2];
    do_read(32'h0000_2010, 4, d, r, lat, st);
    checks++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat != 3) begin
      errors++;
      $display("FAIL rd_stall_data: data=%h resp=%b lat=%0d want deadbeef 00 3",
               d, r, lat);
    end
    checks++;
    if (!st || ar_n[2] - t0 != 1 || ar_a[2] !== 32'h0000_2010) begin
      errors++;
      $display("FAIL rd_stall_hold: stable=%0d fwd=%0d addr=%h want 1 1 00002010",
               st, ar_n[2] - t0, ar_a[2]);
    end
  endtask

  task automatic test_concurrent();
    logic [31:0] d;
    logic [1:0]  rr, wr;
    int rl, wl, r0, w3, rt, wt, c0;
    bit st;
    rdata_l[0] = 32'h0BAD_F00D;
    rresp_l[0] = 2'b00;
    bresp_l[3] = 2'b00;
    r0 = ar_n[0]; w3 = aw_n[3]; rt = ar_tot; wt = aw_tot; c0 = cross_n;
    fork
      do_read(32'h0000_0010, 0, d, rr, rl, st);
      do_write(32'h0000_3008, 32'h5555_AAAA, 4'hF, 0, 0, wr, wl);
    join
    repeat (2) @(negedge clk);
    checks++;
    if (d !== 32'h0BAD_F00D || rr !== 2'b00 || rl != 3 ||
        wr !== 2'b00 || wl != 3) begin
      errors++;
      $display("FAIL conc_resp: rd=%h/%b/%0d wr=%b/%0d",
               d, rr, rl, wr, wl);
    end
    checks++;
    if (ar_n[0] - r0 != 1 || ar_tot - rt != 1 || aw_n[3] - w3 != 1 ||
        aw_tot - wt != 1 || cross_n != c0) begin
      errors++;
      $display("FAIL conc_lanes: ar0=%0d art=%0d aw3=%0d awt=%0d cross=%0d",
               ar_n[0] - r0, ar_tot - rt, aw_n[3] - w3, aw_tot - wt,
               cross_n - c0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, c, bad;
    bit st;
    rv_en[2] = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      bus.S_ARADDR  = 32'h0000_2020;
      bus.S_ARVALID = 1'b1;
      c++;
    end while (!bus.S_ARREADY && c < 50);
    @(negedge clk);
    bus.S_ARVALID = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.M_RREADY !== 4'b0100) begin
      errors++;
      $display("FAIL abort_wait: m_rready=%b want 0100", bus.M_RREADY);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rv_en[2] = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.S_RVALID || bus.M_RREADY != 0 || bus.M_ARVALID != 0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d busy cycles after reset want 0", bad);
    end
    rdata_l[2] = 32'hC0DE_0002;
    do_read(32'h0000_2020, 0, d, r, lat, st);
    checks++;
    if (d !== 32'hC0DE_0002 || lat != 3) begin
      errors++;
      $display("FAIL abort_recover: data=%h lat=%0d want c0de0002 3", d, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, dat, got;
    logic [3:0]  s;
    logic [1:0]  r, er;
    logic [31:0] ed;
    int slot, lat, elat, idx, n0, t0, c0;
    bit hit, st;
    c0 = cross_n;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) begin
        rdata_l[i] = $urandom;
        rresp_l[i] = 2'($urandom_range(0, 3));
        bresp_l[i] = 2'($urandom_range(0, 3));
      end
      slot = $urandom_range(0, 5);
      a    = 32'(slot) * 32'h1000 + (32'($urandom_range(0, 4095)) & ~32'h3);
      idx  = int'(a >> 12);
      hit  = idx < N;
      elat = hit ? 3 : 1;
      if ($urandom_range(0, 1) == 1) begin
        n0  = hit ? ar_n[idx] : 0;
        t0  = ar_tot;
        er  = hit ? rresp_l[idx] : 2'b11;
        ed  = hit ? rdata_l[idx] : 32'h0;
        do_read(a, $urandom_range(0, 3), got, r, lat, st);
        repeat (2) @(negedge clk);
        checks++;
        if (got !== ed || r !== er || lat != elat || !st) begin
          errors++;
          $display("FAIL rand%0d_rd: a=%h data=%h resp=%b lat=%0d want %h %b %0d",
                   it, a, got, r, lat, ed, er, elat);
        end
        checks++;
        if (ar_tot - t0 != (hit ? 1 : 0) ||
            (hit && (ar_n[idx] - n0 != 1 || ar_a[idx] !== a))) begin
          errors++;
          $display("FAIL rand%0d_rd_fwd: a=%h fwd=%0d want %0d",
                   it, a, ar_tot - t0, hit ? 1 : 0);
        end
      end else begin
        dat = $urandom;
        s   = 4'($urandom_range(1, 15));
        n0  = hit ? aw_n[idx] : 0;
        t0  = aw_tot;
        er  = hit ? bresp_l[idx] : 2'b11;
        do_write(a, dat, s, $urandom_range(0, 3), $urandom_range(0, 3),
                 r, lat);
        repeat (2) @(negedge clk);
        checks++;
        if (r !== er || lat != elat) begin
          errors++;
          $display("FAIL rand%0d_wr: a=%h resp=%b lat=%0d want %b %0d",
                   it, a, r, lat, er, elat);
        end
        checks++;
        if (aw_tot - t0 != (hit ? 1 : 0) ||
            (hit && (aw_n[idx] - n0 != 1 || aw_a[idx] !== a ||
                     w_d[idx] !== dat || w_s[idx] !== s))) begin
          errors++;
          $display("FAIL rand%0d_wr_fwd: a=%h fwd=%0d want %0d",
                   it, a, aw_tot - t0, hit ? 1 : 0);
        end
      end
    end
    checks++;
    if (cross_n != c0) begin
      errors++;
      $display("FAIL rand_cross: %0d multi-lane cycles want 0", cross_n - c0);
    end
  endtask

`ifdef AXI4_LITE_DEMUX_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] d;
    logic [1:0]  r;
    int lat, t0;
    bit st;
    bv_en[1] = 1'b0;
    do_write(32'h0000_1000, 32'h1, 4'hF, 0, 0, r, lat);
    bv_en[1] = 1'b1;
    checks++;
    if (r !== 2'b10 || lat != 17 || fault !== 4'b0010) begin
      errors++;
      $display("FAIL timeout_wr: resp=%b lat=%0d fault=%b want 10 17 0010",
               r, lat, fault);
    end
    t0 = aw_tot;
    do_write(32'h0000_1010, 32'h2, 4'hF, 0, 0, r, lat);
    repeat (2) @(negedge clk);
    checks++;
    if (r !== 2'b10 || lat != 1 || aw_tot != t0) begin
      errors++;
      $display("FAIL timeout_fault_wr: resp=%b lat=%0d fwd=%0d want 10 1 0",
               r, lat, aw_tot - t0);
    end
    t0 = ar_tot;
    do_read(32'h0000_1020, 0, d, r, lat, st);
    checks++;
    if (r !== 2'b10 || d !== 32'h0 || lat != 1 || ar_tot != t0) begin
      errors++;
      $display("FAIL timeout_fault_rd: resp=%b data=%h lat=%0d want 10 0 1",
               r, d, lat);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fault !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_clear: fault=%b want 0000", fault);
    end
  endtask
`endif

  initial begin
    aw_rdy = '1; w_rdy = '1; ar_rdy = '1; bv_en = '1; rv_en = '1;
    for (int i = 0; i < N; i++) begin
      bresp_l[i] = 2'b00; rresp_l[i] = 2'b00; rdata_l[i] = '0;
      aw_n[i] = 0; w_n[i] = 0; ar_n[i] = 0;
    end
    bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = '0; bus.S_WSTRB = '0; bus.S_WVALID = 1'b0;
    bus.S_BREADY = 1'b0;
    bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
    test_reset();
    test_write_basic();
    test_write_order();
    test_read_miss();
    test_read_stall();
    test_concurrent();
    test_abort();
    test_random();
`ifdef AXI4_LITE_DEMUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
